alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 8-bit ALU (AND/OR/ADD/MOV functions) between two requesters, e.g. the instruction datapath (requester 0) and an auxiliary compare/branch unit (requester 1).
- Arbitrates between them, latches the operands and function select, and drives the ALU.
- Waits a fixed number of clock cycles for the result to settle, then returns the result with the requester ID over a valid/ready response channel.

Parameters:
- ALU_LAT, 1: cycles from operand latch to result capture. Legal range 1..15; the ALU's #1 combinational delay fits within one cycle.
- SEL_W, 3: width of the ALU function select.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_DATA1  in  8  requester 0 operand 1.
- REQ0_DATA2  in  8  requester 0 operand 2.
- REQ0_SELECT  in  SEL_W  requester 0 ALU function.
- REQ1_VALID, REQ1_READY, REQ1_DATA1, REQ1_DATA2, REQ1_SELECT: same as requester 0, for requester 1.
- ALU_DATA1  out  8  registered operand 1 to the ALU.
- ALU_DATA2  out  8  registered operand 2 to the ALU.
- ALU_SELECT  out  SEL_W  registered function to the ALU.
- ALU_RESULT  in  8  ALU result.
- RSP_VALID  out  1  response holds a result.
- RSP_READY  in  1  consumer takes the response.
- RSP_ID  out  1  requester that owns RSP_RESULT.
- RSP_RESULT  out  8  captured ALU result.
- BUSY  out  1  high in any state other than IDLE.
- OPS_DONE  out  8  count of completed responses, wrapping.

Behaviour:
- Reset:
  - Any rising CLK edge with RESET=0 sets state=IDLE.
  - ALU_DATA1, ALU_DATA2, ALU_SELECT, RSP_RESULT, RSP_ID, OPS_DONE = 0.
  - RSP_VALID = 0; LAST (last grant pointer) = 1.
  - An in-flight operation is dropped; no response is produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Combinational grant. GNT = the only valid requester when one is valid; when both are valid, the arbitration policy decides (see Optional Feature).
  - REQn_READY = (state==IDLE) && REQn_VALID && GNT==n. Both READY signals are low in every other state.
  - Handshake (VALID && READY): latch the granted DATA1/DATA2/SELECT into the ALU_* registers and the ID into RSP_ID, set LAST=GNT, load CNT=ALU_LAT, go to WAIT.
  - No valid requester: stay in IDLE; the ALU_* outputs hold their last values.
- WAIT:
  - CNT decrements every cycle.
  - On the edge where CNT==1: RSP_RESULT <= ALU_RESULT, RSP_VALID <= 1, go to RESP.
  - Latency: with the handshake at edge N, RSP_VALID rises at edge N+ALU_LAT.
- RESP:
  - RSP_RESULT and RSP_ID are held stable while RSP_VALID=1 && RSP_READY=0.
  - On the RSP_READY edge: RSP_VALID <= 0, OPS_DONE <= OPS_DONE+1 (255 wraps to 0), go to IDLE.
  - A new grant is possible on the cycle after that (no same-cycle bypass).
  - Best-case throughput is one operation per ALU_LAT+2 cycles.
- ALU_* outputs stay constant from the latch through the end of RESP.
- Requesters may drop VALID before a handshake. The grant is re-evaluated every IDLE cycle and no requester is locked.
- SELECT values are passed through unchecked; decoding undefined codes is the ALU's job.
- RSP_READY held high in advance: the response completes on the first RESP edge. RSP_VALID is therefore high for exactly one cycle.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin. When both requesters are valid in IDLE, GNT = ~LAST. Because LAST resets to 1, requester 0 wins the first tie.
- Not defined: fixed priority. Requester 0 always wins a tie. LAST is still updated but ignored.
- A single valid requester is granted identically in both builds.

Test Plan:
- Reset, then REQ0 DATA1=8'hA5, DATA2=8'h0F, SELECT=3'b011, ALU modelled as OR, ALU_LAT=1 -> REQ0_READY=1 for one cycle; ALU_* = A5/0F/3 next edge; RSP_VALID=1 with RSP_RESULT=8'hAF and RSP_ID=0 one edge later; OPS_DONE=1 after RSP_READY.
- Both requesters held valid for 4 operations, RSP_READY tied high:
  - With ALU_ARB_RR_EN defined -> RSP_ID sequence 0,1,0,1.
  - Without it -> sequence 0,0,0,0 and REQ1_READY never asserted.
- ALU_LAT=4, request accepted at edge 10 -> RSP_VALID rises at edge 14; BUSY=1 from edge 10 until RSP_READY completes.
- RSP_READY held low for 5 cycles in RESP, REQ1 valid throughout -> RSP_RESULT and RSP_ID stable; REQ1_READY stays 0; grant to REQ1 occurs the cycle after RSP_READY.
- RESET driven low during WAIT -> next edge gives state IDLE, BUSY=0, RSP_VALID=0, OPS_DONE=0; no response appears for the dropped operation.
- 256 back-to-back completions -> OPS_DONE wraps from 8'hFF to 8'h00.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 8-bit ALU between two requesters.
// Grants one requester in IDLE, latches its operands into the ALU registers,
// waits ALU_LAT cycles, then returns the captured result over a valid/ready channel.
// Optional macro ALU_ARB_RR_EN: round-robin tie-break (default: requester 0 wins ties).
module alu_share_arbiter #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned SEL_W   = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [7:0]       REQ0_DATA1,
    input  logic [7:0]       REQ0_DATA2,
    input  logic [SEL_W-1:0] REQ0_SELECT,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [7:0]       REQ1_DATA1,
    input  logic [7:0]       REQ1_DATA2,
    input  logic [SEL_W-1:0] REQ1_SELECT,
    output logic [7:0]       ALU_DATA1,
    output logic [7:0]       ALU_DATA2,
    output logic [SEL_W-1:0] ALU_SELECT,
    input  logic [7:0]       ALU_RESULT,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [7:0]       RSP_RESULT,
    output logic             BUSY,
    output logic [7:0]       OPS_DONE
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [7:0]       alu_data1_q, alu_data1_d;
    logic [7:0]       alu_data2_q, alu_data2_d;
    logic [SEL_W-1:0] alu_select_q, alu_select_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [7:0]       ops_done_q, ops_done_d;
    logic             gnt;
    logic             hs;

`ifndef ALU_ARB_RR_EN
    // Tie-break ignores the last-grant pointer in this build.
    logic unused_last;
    assign unused_last = last_q;
`endif

    // Grant selection: lone valid requester wins; a tie goes to the policy.
    always_comb begin
        gnt = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_ARB_RR_EN
            gnt = ~last_q;
`else
            gnt = 1'b0;
`endif
        end else if (REQ1_VALID) begin
            gnt = 1'b1;
        end
    end

    assign REQ0_READY = (state_q == StIdle) && REQ0_VALID && !gnt;
    assign REQ1_READY = (state_q == StIdle) && REQ1_VALID && gnt;
    assign hs         = REQ0_READY || REQ1_READY;

    // Next-state logic for the grant / wait / respond sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        alu_data1_d  = alu_data1_q;
        alu_data2_d  = alu_data2_q;
        alu_select_d = alu_select_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        ops_done_d   = ops_done_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    alu_data1_d  = gnt ? REQ1_DATA1 : REQ0_DATA1;
                    alu_data2_d  = gnt ? REQ1_DATA2 : REQ0_DATA2;
                    alu_select_d = gnt ? REQ1_SELECT : REQ0_SELECT;
                    rsp_id_d     = gnt;
                    last_d       = gnt;
                    cnt_d        = 4'(ALU_LAT);
                    state_d      = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_result_d = ALU_RESULT;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 8'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset; in-flight work is dropped.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_q       <= 1'b1;
            alu_data1_q  <= 8'd0;
            alu_data2_q  <= 8'd0;
            alu_select_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 8'd0;
            ops_done_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            alu_data1_q  <= alu_data1_d;
            alu_data2_q  <= alu_data2_d;
            alu_select_q <= alu_select_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign ALU_DATA1  = alu_data1_q;
    assign ALU_DATA2  = alu_data2_q;
    assign ALU_SELECT = alu_select_q;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ID     = rsp_id_q;
    assign RSP_RESULT = rsp_result_q;
    assign BUSY       = (state_q != StIdle);
    assign OPS_DONE   = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=4.
// Honours ALU_ARB_RR_EN for the tie-break expectations.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0v, r1v, v4, rdy4, rsp_rdy, zero;
    logic [7:0] r0d1, r0d2, r1d1, r1d2;
    logic [2:0] r0sel, r1sel;

    logic       rdy0_1, rdy1_1, rv_1, rid_1, busy_1;
    logic [7:0] ad1_1, ad2_1, ares_1, rres_1, ops_1;
    logic [2:0] asel_1;
    logic       rdy0_4, rdy1_4, rv_4, rid_4, busy_4;
    logic [7:0] ad1_4, ad2_4, ares_4, rres_4, ops_4;
    logic [2:0] asel_4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // ALU model: 0 AND, 1 ADD, 2 MOV (DATA1), 3 OR, others 0.
    function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a,
                                         input logic [7:0] b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a + b;
            3'd2:    return a;
            3'd3:    return a | b;
            default: return 8'd0;
        endcase
    endfunction

    assign ares_1 = alu_f(asel_1, ad1_1, ad2_1);
    assign ares_4 = alu_f(asel_4, ad1_4, ad2_4);

    alu_share_arbiter #(.ALU_LAT(1), .SEL_W(3)) u_dut1 (
        .CLK(clk), .RESET(rst_n),
        .REQ0_VALID(r0v), .REQ0_READY(rdy0_1), .REQ0_DATA1(r0d1), .REQ0_DATA2(r0d2),
        .REQ0_SELECT(r0sel),
        .REQ1_VALID(r1v), .REQ1_READY(rdy1_1), .REQ1_DATA1(r1d1), .REQ1_DATA2(r1d2),
        .REQ1_SELECT(r1sel),
        .ALU_DATA1(ad1_1), .ALU_DATA2(ad2_1), .ALU_SELECT(asel_1), .ALU_RESULT(ares_1),
        .RSP_VALID(rv_1), .RSP_READY(rsp_rdy), .RSP_ID(rid_1), .RSP_RESULT(rres_1),
        .BUSY(busy_1), .OPS_DONE(ops_1)
    );

    alu_share_arbiter #(.ALU_LAT(4), .SEL_W(3)) u_dut4 (
        .CLK(clk), .RESET(rst_n),
        .REQ0_VALID(v4), .REQ0_READY(rdy0_4), .REQ0_DATA1(r0d1), .REQ0_DATA2(r0d2),
        .REQ0_SELECT(r0sel),
        .REQ1_VALID(zero), .REQ1_READY(rdy1_4), .REQ1_DATA1(r1d1), .REQ1_DATA2(r1d2),
        .REQ1_SELECT(r1sel),
        .ALU_DATA1(ad1_4), .ALU_DATA2(ad2_4), .ALU_SELECT(asel_4), .ALU_RESULT(ares_4),
        .RSP_VALID(rv_4), .RSP_READY(rdy4), .RSP_ID(rid_4), .RSP_RESULT(rres_4),
        .BUSY(busy_4), .OPS_DONE(ops_4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int         n, r1cnt, seen;
    logic [0:0] ids [4];
    logic [0:0] exp_ids [4];
    int         exp_r1cnt;

    initial begin
        rst_n = 1'b1; r0v = 0; r1v = 0; v4 = 0; rdy4 = 0; rsp_rdy = 0; zero = 0;
        r0d1 = 0; r0d2 = 0; r1d1 = 0; r1d2 = 0; r0sel = 0; r1sel = 0;
        #2;

        // Reset values and a single ALU_LAT=1 operation (OR).
        do_reset();
        check("rst_busy", busy_1, 0);
        check("rst_rsp_valid", rv_1, 0);
        check("rst_ops", ops_1, 0);
        check("rst_alu_d1", ad1_1, 0);
        check("rst_rsp_id", rid_1, 0);
        r0d1 = 8'hA5; r0d2 = 8'h0F; r0sel = 3'b011; r0v = 1;
        #1;
        check("t1_ready0", rdy0_1, 1);
        tick();
        r0v = 0;
        check("t1_alu_d1", ad1_1, 8'hA5);
        check("t1_alu_d2", ad2_1, 8'h0F);
        check("t1_alu_sel", asel_1, 3);
        check("t1_busy", busy_1, 1);
        check("t1_ready0_wait", rdy0_1, 0);
        check("t1_rsp_valid_lo", rv_1, 0);
        tick();
        check("t1_rsp_valid", rv_1, 1);
        check("t1_rsp_result", rres_1, 8'hAF);
        check("t1_rsp_id", rid_1, 0);
        rsp_rdy = 1;
        tick();
        rsp_rdy = 0;
        check("t1_rsp_valid_done", rv_1, 0);
        check("t1_ops", ops_1, 1);
        check("t1_busy_done", busy_1, 0);

        // Both requesters held valid, RSP_READY high, four operations.
        do_reset();
        r0d1 = 8'h01; r0d2 = 8'h02; r0sel = 3'd1;
        r1d1 = 8'h10; r1d2 = 8'h20; r1sel = 3'd2;
        r0v = 1; r1v = 1; rsp_rdy = 1; n = 0; r1cnt = 0;
        #1;
        for (int c = 0; c < 60 && n < 4; c++) begin
            if (rdy1_1) r1cnt++;
            tick();
            if (rv_1) begin
                ids[n] = rid_1;
                check("t2_result", rres_1, rid_1 ? 8'h10 : 8'h03);
                n++;
            end
        end
        r0v = 0; r1v = 0;
        check("t2_count", n, 4);
`ifdef ALU_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_r1cnt = 2;
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_r1cnt = 0;
`endif
        for (int i = 0; i < 4; i++) check("t2_id", ids[i], exp_ids[i]);
        check("t2_r1_ready_cnt", r1cnt, exp_r1cnt);
        tick();
        rsp_rdy = 0;
        check("t2_ops", ops_1, 4);
        check("t2_rsp_valid", rv_1, 0);

        // ALU_LAT=4 latency and BUSY span.
        r0d1 = 8'hA5; r0d2 = 8'h0F; r0sel = 3'd0; v4 = 1;
        #1;
        check("t3_ready0", rdy0_4, 1);
        tick();
        v4 = 0;
        check("t3_busy_e0", busy_4, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t3_rsp_valid_lo", rv_4, 0);
            check("t3_busy", busy_4, 1);
        end
        tick();
        check("t3_rsp_valid", rv_4, 1);
        check("t3_rsp_result", rres_4, 8'h05);
        check("t3_busy_resp", busy_4, 1);
        rdy4 = 1;
        tick();
        rdy4 = 0;
        check("t3_rsp_valid_done", rv_4, 0);
        check("t3_busy_done", busy_4, 0);
        check("t3_ops", ops_4, 1);

        // Back-pressure in RESP while requester 1 waits.
        r0d1 = 8'h33; r0d2 = 8'h0F; r0sel = 3'd0; r0v = 1;
        #1;
        tick();
        r0v = 0;
        r1d1 = 8'h10; r1d2 = 8'h20; r1sel = 3'd2; r1v = 1;
        #1;
        check("t4_ready1_wait", rdy1_1, 0);
        tick();
        check("t4_rsp_valid", rv_1, 1);
        check("t4_rsp_result", rres_1, 8'h03);
        check("t4_rsp_id", rid_1, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_hold_valid", rv_1, 1);
            check("t4_hold_result", rres_1, 8'h03);
            check("t4_hold_id", rid_1, 0);
            check("t4_hold_ready1", rdy1_1, 0);
        end
        rsp_rdy = 1;
        tick();
        rsp_rdy = 0;
        check("t4_ready1_after", rdy1_1, 1);
        tick();
        r1v = 0;
        check("t4_alu_d1", ad1_1, 8'h10);
        check("t4_busy", busy_1, 1);
        tick();
        check("t4_rsp_valid1", rv_1, 1);
        check("t4_rsp_id1", rid_1, 1);
        check("t4_rsp_result1", rres_1, 8'h10);
        rsp_rdy = 1;
        tick();
        rsp_rdy = 0;

        // Reset during WAIT drops the operation.
        r0d1 = 8'h77; r0d2 = 8'hFF; r0sel = 3'd0; v4 = 1;
        #1;
        tick();
        v4 = 0;
        tick();
        check("t5_busy_wait", busy_4, 1);
        rst_n = 0;
        tick();
        check("t5_busy", busy_4, 0);
        check("t5_rsp_valid", rv_4, 0);
        check("t5_ops", ops_4, 0);
        check("t5_alu_d1", ad1_4, 0);
        check("t5_rsp_result", rres_4, 0);
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rv_4 || busy_4) seen++;
        end
        check("t5_no_response", seen, 0);

        // 256 back-to-back completions wrap OPS_DONE.
        check("t6_ops_start", ops_1, 0);
        r0d1 = 8'h01; r0d2 = 8'h01; r0sel = 3'd1; r0v = 1; rsp_rdy = 1; n = 0;
        for (int c = 0; c < 1000 && n < 256; c++) begin
            tick();
            if (rv_1) n++;
        end
        check("t6_count", n, 256);
        check("t6_ops_ff", ops_1, 8'hFF);
        r0v = 0;
        tick();
        rsp_rdy = 0;
        check("t6_ops_wrap", ops_1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
